decode_writeback_rf: RTL and testbench
======================================

Name: decode_writeback_rf

Overview:
Parametrised successor to the Y86-64 decode/writeback stage. It holds the architectural register file and selects srcA/srcB from icode/rA/rB. The decode result sits in a valid/ready output register, and the writeback port has conditional-move qualification, same-cycle forwarding and dual-write priority. It sits between fetch and execute, and takes its writeback inputs from the memory stage.

Parameters:
DATA_W, 64, register and value width in bits
NREGS, 15, number of implemented registers (1..15); index 4'hF always means "none"
RSP_IDX, 4, index of the stack pointer
RSP_INIT, 10, reset value of register RSP_IDX

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
dec_valid  in  1  decode request valid
dec_ready  out  1  decode request accepted this cycle when high together with dec_valid
dec_icode  in  4  instruction code
dec_rA  in  4  rA field
dec_rB  in  4  rB field
out_valid  out  1  decode result valid
out_ready  in  1  downstream accepts the result
srcA  out  4  selected A source index (4'hF = none)
srcB  out  4  selected B source index (4'hF = none)
valA  out  DATA_W  A operand
valB  out  DATA_W  B operand
wb_valid  in  1  writeback request this cycle
wb_icode  in  4  icode of the retiring instruction
wb_rA  in  4  rA of the retiring instruction
wb_rB  in  4  rB of the retiring instruction
wb_cnd  in  1  condition result; qualifies cmovXX (icode 2)
wb_valE  in  DATA_W  ALU result
wb_valM  in  DATA_W  memory result

Behaviour:
- Reset (asynchronous, active-high):
  - Every register is 0 except reg[RSP_IDX] = RSP_INIT.
  - out_valid=0, valA=0, valB=0, srcA=srcB=4'hF.
  - A pending result is discarded.
  - dec_ready=1 after reset deasserts.
- dec_ready = !out_valid || out_ready (combinational). A request is accepted on a rising edge with dec_valid && dec_ready.
- Latency: result is registered. out_valid goes high on the edge after acceptance and stays high until out_valid && out_ready, unless a new accept replaces it the same edge.
- While stalled (out_valid && !out_ready): srcA/srcB/valA/valB hold. Later writebacks do not refresh the held values.
- srcA selection:
  - icode 9 or B -> RSP_IDX
  - icode 2, 4, 6 or A -> rA
  - else 4'hF
- srcB selection:
  - icode 8, 9, A or B -> RSP_IDX
  - icode 4, 5 or 6 -> rB
  - else 4'hF
- valX = 0 when srcX is 4'hF or srcX >= NREGS.
- Writeback occurs on the rising edge when wb_valid=1.
- destE selection:
  - icode 8, 9, A or B -> RSP_IDX
  - icode 3 or 6 -> rB
  - icode 2 -> rB if wb_cnd=1, else 4'hF
  - else 4'hF
- destM: icode 5 or B -> rA; else 4'hF.
- A dest of 4'hF or >= NREGS performs no write.
- If destE == destM (both valid), valM wins (popq %rsp case).
- Forwarding: if an accept and wb_valid coincide and srcX equals a valid dest, valX captures the incoming value, with valM priority over valE. Otherwise valX captures the pre-edge register contents.
- Undefined icodes (C..F) select no sources and perform no writes.

Optional Feature:
Macro DECODE_RF_DBG_EN.
- Defined: adds two ports.
  - dbg_addr  in  4
  - dbg_data  out  DATA_W
  - dbg_data is a combinational read of reg[dbg_addr]; it returns 0 for 4'hF or >= NREGS.
  - The read has no side effects and ignores forwarding.
- Undefined: the ports do not exist and no read logic is built.

Test Plan:
- Reset, then decode icode A (pushq), rA=2 -> one cycle later out_valid=1, srcA=2, srcB=4, valA=0, valB=10.
- wb icode 3 (irmovq), rB=1, valE=0x55 held for one edge; decode icode 6, rA=1, rB=1 on the next cycle -> valA=valB=0x55.
- Same-edge wb icode B (popq), rA=4, valE=0x18, valM=0x77 with a decode accept of icode A, rA=4 -> reg4=0x77, valA=0x77 (forwarded, M priority).
- wb icode 2, rB=3, valE=9, wb_cnd=0 -> reg3 unchanged. Repeat with wb_cnd=1 -> reg3=9.
- Hold out_ready=0 with a result pending, then assert dec_valid -> dec_ready=0 and outputs hold. Raise out_ready -> accept the same edge and the new result appears the next cycle.
- Assert reset mid-stall, then NREGS=8 with wb icode 3 and rB=9 -> out_valid=0 and reg4=10 after reset. The rB=9 write is ignored and a decode with srcA=9 returns 0.

Source files
------------

// File: rtl/decode_writeback_rf.sv
// Y86-64 decode/writeback stage: architectural register file, operand select with
// writeback forwarding, valid/ready result register. Optional debug read port: DECODE_RF_DBG_EN.
module decode_writeback_rf #(
   parameter int                DATA_W   = 64,
   parameter int                NREGS    = 15,
   parameter logic [3:0]        RSP_IDX  = 4'd4,
   parameter logic [DATA_W-1:0] RSP_INIT = DATA_W'(10)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              dec_valid,
   output logic              dec_ready,
   input  logic [3:0]        dec_icode,
   input  logic [3:0]        dec_rA,
   input  logic [3:0]        dec_rB,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        srcA,
   output logic [3:0]        srcB,
   output logic [DATA_W-1:0] valA,
   output logic [DATA_W-1:0] valB,
   input  logic              wb_valid,
   input  logic [3:0]        wb_icode,
   input  logic [3:0]        wb_rA,
   input  logic [3:0]        wb_rB,
   input  logic              wb_cnd,
   input  logic [DATA_W-1:0] wb_valE,
   input  logic [DATA_W-1:0] wb_valM
`ifdef DECODE_RF_DBG_EN
   ,
   input  logic [3:0]        dbg_addr,
   output logic [DATA_W-1:0] dbg_data
`endif
);

   localparam logic [3:0] NONE = 4'hF;

   logic [DATA_W-1:0] regs_r [NREGS];
   logic              out_valid_r;
   logic [3:0]        src_a_r, src_b_r;
   logic [DATA_W-1:0] val_a_r, val_b_r;
   logic [3:0]        src_a_s, src_b_s, dest_e_s, dest_m_s;
   logic [DATA_W-1:0] fwd_a_s, fwd_b_s;
   logic              accept_s;

   function automatic logic [3:0] src_a_f(input logic [3:0] icode, input logic [3:0] ra);
      case (icode)
         4'h9, 4'hB:             src_a_f = RSP_IDX;
         4'h2, 4'h4, 4'h6, 4'hA: src_a_f = ra;
         default:                src_a_f = NONE;
      endcase
   endfunction

   function automatic logic [3:0] src_b_f(input logic [3:0] icode, input logic [3:0] rb);
      case (icode)
         4'h8, 4'h9, 4'hA, 4'hB: src_b_f = RSP_IDX;
         4'h4, 4'h5, 4'h6:       src_b_f = rb;
         default:                src_b_f = NONE;
      endcase
   endfunction

   function automatic logic [3:0] dest_e_f(input logic [3:0] icode, input logic [3:0] rb,
                                           input logic cnd);
      case (icode)
         4'h8, 4'h9, 4'hA, 4'hB: dest_e_f = RSP_IDX;
         4'h3, 4'h6:             dest_e_f = rb;
         4'h2:                   dest_e_f = cnd ? rb : NONE;
         default:                dest_e_f = NONE;
      endcase
   endfunction

   function automatic logic [3:0] dest_m_f(input logic [3:0] icode, input logic [3:0] ra);
      case (icode)
         4'h5, 4'hB: dest_m_f = ra;
         default:    dest_m_f = NONE;
      endcase
   endfunction

   // Indices of 4'hF or beyond the implemented file match no entry and read as zero.
   function automatic logic [DATA_W-1:0] reg_read_f(input logic [3:0] idx);
      logic [DATA_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < NREGS; i++) begin
         acc = acc | ({DATA_W{idx == 4'(i)}} & regs_r[i]);
      end
      return acc;
   endfunction

   assign src_a_s   = src_a_f(dec_icode, dec_rA);
   assign src_b_s   = src_b_f(dec_icode, dec_rB);
   assign dest_e_s  = dest_e_f(wb_icode, wb_rB, wb_cnd);
   assign dest_m_s  = dest_m_f(wb_icode, wb_rA);
   assign dec_ready = !out_valid_r || out_ready;
   assign accept_s  = dec_valid && dec_ready;

   // Operand capture values: same-edge writeback bypasses the file, valM over valE.
   always_comb begin
      fwd_a_s = reg_read_f(src_a_s);
      fwd_b_s = reg_read_f(src_b_s);
      if (src_a_s == NONE || int'(src_a_s) >= NREGS) fwd_a_s = '0;
      else if (wb_valid && src_a_s == dest_m_s)      fwd_a_s = wb_valM;
      else if (wb_valid && src_a_s == dest_e_s)      fwd_a_s = wb_valE;
      else                                           fwd_a_s = reg_read_f(src_a_s);
      if (src_b_s == NONE || int'(src_b_s) >= NREGS) fwd_b_s = '0;
      else if (wb_valid && src_b_s == dest_m_s)      fwd_b_s = wb_valM;
      else if (wb_valid && src_b_s == dest_e_s)      fwd_b_s = wb_valE;
      else                                           fwd_b_s = reg_read_f(src_b_s);
   end

   // Result register; values change only on accept so a stall holds them.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         src_a_r     <= NONE;
         src_b_r     <= NONE;
         val_a_r     <= '0;
         val_b_r     <= '0;
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         src_a_r     <= src_a_s;
         src_b_r     <= src_b_s;
         val_a_r     <= fwd_a_s;
         val_b_r     <= fwd_b_s;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   // Register file writes; destM checked first so it wins a dual write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= (4'(i) == RSP_IDX) ? RSP_INIT : '0;
         end
      end else if (wb_valid) begin
         for (int i = 0; i < NREGS; i++) begin
            if (dest_m_s == 4'(i))      regs_r[i] <= wb_valM;
            else if (dest_e_s == 4'(i)) regs_r[i] <= wb_valE;
         end
      end
   end

   assign out_valid = out_valid_r;
   assign srcA      = src_a_r;
   assign srcB      = src_b_r;
   assign valA      = val_a_r;
   assign valB      = val_b_r;

`ifdef DECODE_RF_DBG_EN
   always_comb dbg_data = reg_read_f(dbg_addr);
`else
   // build without the debug read port
`endif

endmodule

// File: tb/tb_decode_writeback_rf.sv
// Bench for decode_writeback_rf: default instance (NREGS=15) and an NREGS=8 instance
// driven in parallel, both checked against a register-array reference model.
module tb_decode_writeback_rf;

   logic        clock, reset, rst8;
   logic        dec_valid, out_ready, wb_valid, wb_cnd;
   logic [3:0]  dec_icode, dec_rA, dec_rB, wb_icode, wb_rA, wb_rB;
   logic [63:0] wb_valE, wb_valM;

   logic        o_ready [2];
   logic        o_valid [2];
   logic [3:0]  o_srca  [2];
   logic [3:0]  o_srcb  [2];
   logic [63:0] o_vala  [2];
   logic [63:0] o_valb  [2];

   int n_vec = 0;
   int n_err = 0;

   // reference model state, one set per instance
   logic [63:0] m_rf [2][15];
   logic        m_ov [2];
   logic [3:0]  m_sa [2];
   logic [3:0]  m_sb [2];
   logic [63:0] m_va [2];
   logic [63:0] m_vb [2];
   int          nr   [2] = '{15, 8};

   decode_writeback_rf dut (
      .clock(clock), .reset(reset), .dec_valid(dec_valid), .dec_ready(o_ready[0]),
      .dec_icode(dec_icode), .dec_rA(dec_rA), .dec_rB(dec_rB),
      .out_valid(o_valid[0]), .out_ready(out_ready), .srcA(o_srca[0]), .srcB(o_srcb[0]),
      .valA(o_vala[0]), .valB(o_valb[0]), .wb_valid(wb_valid), .wb_icode(wb_icode),
      .wb_rA(wb_rA), .wb_rB(wb_rB), .wb_cnd(wb_cnd), .wb_valE(wb_valE), .wb_valM(wb_valM));

   decode_writeback_rf #(.NREGS(8)) dut8 (
      .clock(clock), .reset(rst8), .dec_valid(dec_valid), .dec_ready(o_ready[1]),
      .dec_icode(dec_icode), .dec_rA(dec_rA), .dec_rB(dec_rB),
      .out_valid(o_valid[1]), .out_ready(out_ready), .srcA(o_srca[1]), .srcB(o_srcb[1]),
      .valA(o_vala[1]), .valB(o_valb[1]), .wb_valid(wb_valid), .wb_icode(wb_icode),
      .wb_rA(wb_rA), .wb_rB(wb_rB), .wb_cnd(wb_cnd), .wb_valE(wb_valE), .wb_valM(wb_valM));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] ref_src_a(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h9, 4'hB}) return 4'd4;
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
      return 4'hF;
   endfunction

   function automatic logic [3:0] ref_src_b(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
      if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
      return 4'hF;
   endfunction

   task automatic model_reset(input int k);
      for (int i = 0; i < 15; i++) m_rf[k][i] = (i == 4) ? 64'd10 : 64'd0;
      m_ov[k] = 1'b0;
      m_sa[k] = 4'hF;
      m_sb[k] = 4'hF;
      m_va[k] = 64'd0;
      m_vb[k] = 64'd0;
   endtask

   // Model: apply the writeback to the file first, then a same-edge read sees the new value.
   task automatic model_step(input int k);
      logic       acc;
      logic [3:0] e, m;
      acc = dec_valid && (!m_ov[k] || out_ready);
      if (wb_valid) begin
         e = 4'hF;
         m = 4'hF;
         if (wb_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) e = 4'd4;
         if (wb_icode inside {4'h3, 4'h6}) e = wb_rB;
         if (wb_icode == 4'h2 && wb_cnd) e = wb_rB;
         if (wb_icode inside {4'h5, 4'hB}) m = wb_rA;
         if (e != 4'hF && int'(e) < nr[k]) m_rf[k][e] = wb_valE;
         if (m != 4'hF && int'(m) < nr[k]) m_rf[k][m] = wb_valM;
      end
      if (acc) begin
         m_ov[k] = 1'b1;
         m_sa[k] = ref_src_a(dec_icode, dec_rA);
         m_sb[k] = ref_src_b(dec_icode, dec_rB);
         m_va[k] = (m_sa[k] != 4'hF && int'(m_sa[k]) < nr[k]) ? m_rf[k][m_sa[k]] : 64'd0;
         m_vb[k] = (m_sb[k] != 4'hF && int'(m_sb[k]) < nr[k]) ? m_rf[k][m_sb[k]] : 64'd0;
      end else if (out_ready) begin
         m_ov[k] = 1'b0;
      end
   endtask

   task automatic cycle();
      logic rk [2];
      #1;
      rk[0] = reset;
      rk[1] = rst8;
      for (int k = 0; k < 2; k++) begin
         if (rk[k]) model_reset(k);
         chk($sformatf("dec_ready%0d", k), {63'd0, o_ready[k]}, {63'd0, !m_ov[k] || out_ready});
      end
      for (int k = 0; k < 2; k++) if (!rk[k]) model_step(k);
      @(posedge clock);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("out_valid%0d", k), {63'd0, o_valid[k]}, {63'd0, m_ov[k]});
         chk($sformatf("srcA%0d", k), {60'd0, o_srca[k]}, {60'd0, m_sa[k]});
         chk($sformatf("srcB%0d", k), {60'd0, o_srcb[k]}, {60'd0, m_sb[k]});
         chk($sformatf("valA%0d", k), o_vala[k], m_va[k]);
         chk($sformatf("valB%0d", k), o_valb[k], m_vb[k]);
      end
   endtask

   task automatic idle();
      dec_valid = 1'b0; dec_icode = 4'h0; dec_rA = 4'hF; dec_rB = 4'hF; out_ready = 1'b1;
      wb_valid = 1'b0; wb_icode = 4'h0; wb_rA = 4'hF; wb_rB = 4'hF; wb_cnd = 1'b0;
      wb_valE = 64'd0; wb_valM = 64'd0;
   endtask

   task automatic dec(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
      dec_valid = 1'b1; dec_icode = ic; dec_rA = ra; dec_rB = rb;
   endtask

   task automatic wb(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                     input logic cnd, input logic [63:0] ve, input logic [63:0] vm);
      wb_valid = 1'b1; wb_icode = ic; wb_rA = ra; wb_rB = rb; wb_cnd = cnd;
      wb_valE = ve; wb_valM = vm;
   endtask

   initial begin
      reset = 1'b1;
      rst8  = 1'b1;
      idle();
      repeat (2) @(posedge clock);
      #1;
      cycle();
      chk("rst_out_valid", {63'd0, o_valid[0]}, 64'd0);
      chk("rst_srcA", {60'd0, o_srca[0]}, 64'hF);
      reset = 1'b0;

      // pushq %rdx
      dec(4'hA, 4'd2, 4'hF); cycle();
      chk("pushq_srcB", {60'd0, o_srcb[0]}, 64'd4);
      chk("pushq_valB", o_valb[0], 64'd10);

      // irmovq then read back through rrmovq-style decode
      idle(); wb(4'h3, 4'hF, 4'd1, 1'b0, 64'h55, 64'h0); cycle();
      idle(); dec(4'h6, 4'd1, 4'd1); cycle();
      chk("irmov_valA", o_vala[0], 64'h55);
      chk("irmov_valB", o_valb[0], 64'h55);

      // popq %rsp with same-edge pushq %rsp decode
      idle(); wb(4'hB, 4'd4, 4'hF, 1'b0, 64'h18, 64'h77); dec(4'hA, 4'd4, 4'hF); cycle();
      chk("popq_fwd_valA", o_vala[0], 64'h77);

      // cmov not taken, then taken
      idle(); wb(4'h2, 4'hF, 4'd3, 1'b0, 64'd9, 64'h0); cycle();
      idle(); dec(4'h6, 4'd3, 4'd3); cycle();
      chk("cmov_nt", o_vala[0], 64'd0);
      idle(); wb(4'h2, 4'hF, 4'd3, 1'b1, 64'd9, 64'h0); cycle();
      idle(); dec(4'h6, 4'd3, 4'd3); cycle();
      chk("cmov_t", o_vala[0], 64'd9);

      // stall: result pending, downstream not ready, writeback to a held source
      idle(); dec(4'h6, 4'd1, 4'd3); cycle();
      idle(); out_ready = 1'b0; dec(4'h9, 4'hF, 4'hF); wb(4'h3, 4'hF, 4'd1, 1'b0, 64'hAB, 64'h0);
      cycle();
      chk("stall_ready", {63'd0, o_ready[0]}, 64'd0);
      chk("stall_hold", o_vala[0], 64'h55);
      idle(); out_ready = 1'b0; dec(4'h9, 4'hF, 4'hF); cycle();
      out_ready = 1'b1; cycle();
      chk("stall_release_srcA", {60'd0, o_srca[0]}, 64'd4);

      // reset while stalled
      idle(); out_ready = 1'b0; dec(4'hA, 4'd1, 4'hF); cycle();
      idle(); out_ready = 1'b0; dec(4'hA, 4'd1, 4'hF); reset = 1'b1; cycle();
      chk("midrst_out_valid", {63'd0, o_valid[0]}, 64'd0);
      reset = 1'b0;
      idle(); dec(4'hA, 4'd4, 4'hF); cycle();
      chk("midrst_rsp", o_vala[0], 64'd10);

      // NREGS=8 instance: out-of-range write and read
      rst8 = 1'b0;
      idle(); wb(4'h3, 4'hF, 4'd9, 1'b0, 64'hDEAD, 64'h0); cycle();
      idle(); dec(4'h2, 4'd9, 4'hF); cycle();
      chk("n8_srcA", {60'd0, o_srca[1]}, 64'd9);
      chk("n8_valA", o_vala[1], 64'd0);
      idle(); dec(4'hA, 4'd4, 4'hF); cycle();
      chk("n8_rsp", o_valb[1], 64'd10);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         dec_valid = 1'($urandom_range(1, 0));
         dec_icode = 4'($urandom_range(15, 0));
         dec_rA    = 4'($urandom_range(15, 0));
         dec_rB    = 4'($urandom_range(15, 0));
         out_ready = ($urandom_range(3, 0) != 0);
         wb_valid  = 1'($urandom_range(1, 0));
         wb_icode  = 4'($urandom_range(15, 0));
         wb_rA     = 4'($urandom_range(15, 0));
         wb_rB     = 4'($urandom_range(15, 0));
         wb_cnd    = 1'($urandom_range(1, 0));
         wb_valE   = {$urandom, $urandom};
         wb_valM   = {$urandom, $urandom};
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
